// File: rtl/io_input_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_input_scan_ctrl
// Description : Scans NCH external input banks. Each bank is synchronised,
//               debounced by visit counting and committed into its input
//               register. The CPU reads the registers by word address.
//               Per-channel "new data" flags are cleared by reads.
// Ports       : io_clk        - I/O clock, rising edge
//               resetn        - asynchronous reset, active-low
//               sw_in         - raw pins, channel k = sw_in[k*WIDTH +: WIDTH]
//               addr          - CPU address, word index = addr[7:2]
//               io_rd         - read strobe, sampled at the io_clk edge
//               io_read_data  - combinational read data, zero-extended
//               data_ready    - per-channel committed-but-unread flags
//               irq           - registered OR of data_ready
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_scan_ctrl #(
    parameter int NCH      = 2,
    parameter int WIDTH    = 5,
    parameter int DEBOUNCE = 4,
    parameter int SCAN_DIV = 8
) (
    input  logic                 io_clk,
    input  logic                 resetn,
    input  logic [NCH*WIDTH-1:0] sw_in,
    input  logic [31:0]          addr,
    input  logic                 io_rd,
    output logic [31:0]          io_read_data,
    output logic [NCH-1:0]       data_ready,
    output logic                 irq
);

    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_ch_w  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [c_div_w-1:0] c_div_last    = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_ch_w-1:0]  c_ch_last     = c_ch_w'(NCH - 1);
    localparam logic [3:0]         c_stab_max    = 4'd15;
    localparam logic [3:0]         c_stab_commit = 4'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SAMPLE = 2'd1,
        S_CHECK  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NCH*WIDTH-1:0] r_sync1;
    logic [NCH*WIDTH-1:0] r_sync2;
    logic [c_div_w-1:0]   r_div;
    logic [c_ch_w-1:0]    r_ch;
    logic [WIDTH-1:0]     r_raw;
    logic [WIDTH-1:0]     r_cand   [NCH];
    logic [WIDTH-1:0]     r_in_reg [NCH];
    logic [3:0]           r_stab   [NCH];
    logic [NCH-1:0]       r_data_ready;
    logic                 r_irq;
    state_t               r_state;
    state_t               w_state_nxt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_tick;
    logic [5:0]       w_idx;
    logic [WIDTH-1:0] w_sync_sel;
    logic [WIDTH-1:0] w_cand_sel;
    logic [WIDTH-1:0] w_in_sel;
    logic [3:0]       w_stab_sel;
    logic             w_do_commit;
    logic             w_unused;

    assign w_tick   = (r_div == c_div_last);
    assign w_idx    = addr[7:2];
    assign w_unused = ^{addr[31:8], addr[1:0]};

    // Values belonging to the channel currently being visited.
    always_comb begin
        w_sync_sel = '0;
        w_cand_sel = '0;
        w_in_sel   = '0;
        w_stab_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_ch == c_ch_w'(k)) begin
                w_sync_sel = r_sync2[k*WIDTH +: WIDTH];
                w_cand_sel = r_cand[k];
                w_in_sel   = r_in_reg[k];
                w_stab_sel = r_stab[k];
            end
        end
    end

    // A commit only happens when the candidate is stable long enough and
    // actually differs, so a steady input never re-raises its flag.
    assign w_do_commit = (r_state == S_COMMIT) &&
                         (w_stab_sel >= c_stab_commit) &&
                         (w_cand_sel != w_in_sel);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_WAIT:   if (w_tick) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_WAIT;
            default:  w_state_nxt = S_WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Synchroniser, divider, channel pointer, sample register
    // ------------------------------------------------------------------
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_div   <= '0;
            r_ch    <= '0;
            r_raw   <= '0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            r_div   <= (r_div == c_div_last) ? '0 : r_div + c_div_w'(1);
            if (r_state == S_SAMPLE) begin
                r_raw <= w_sync_sel;
            end
            if (r_state == S_COMMIT) begin
                r_ch <= (r_ch == c_ch_last) ? '0 : r_ch + c_ch_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce state, input registers and ready flags
    // ------------------------------------------------------------------
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NCH; k++) begin
                r_cand[k]   <= '0;
                r_stab[k]   <= '0;
                r_in_reg[k] <= '0;
            end
            r_data_ready <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if ((r_state == S_CHECK) && (r_ch == c_ch_w'(k))) begin
                    if (r_raw == r_cand[k]) begin
                        if (r_stab[k] != c_stab_max) begin
                            r_stab[k] <= r_stab[k] + 4'd1;
                        end
                    end else begin
                        r_cand[k] <= r_raw;
                        r_stab[k] <= '0;
                    end
                end
                // A commit in the same cycle as a clearing read wins, so the
                // CPU can never miss the newly committed value.
                if (w_do_commit && (r_ch == c_ch_w'(k))) begin
                    r_in_reg[k]     <= r_cand[k];
                    r_data_ready[k] <= 1'b1;
                end else if (io_rd && (w_idx == 6'(k))) begin
                    r_data_ready[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_data_ready;
        end
    end

    // ------------------------------------------------------------------
    // Read map
    // ------------------------------------------------------------------
    always_comb begin
        io_read_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_idx == 6'(k)) begin
                io_read_data[WIDTH-1:0] = r_in_reg[k];
            end
        end
        if (w_idx == 6'(NCH)) begin
            io_read_data[NCH-1:0] = r_data_ready;
        end
        if (!resetn) begin
            io_read_data = '0;
        end
    end

    assign data_ready = r_data_ready;
    assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_input_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_input_scan_ctrl
// Description : Directed self-checking bench for io_input_scan_ctrl with
//               NCH=2, WIDTH=5, DEBOUNCE=4, SCAN_DIV=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_input_scan_ctrl;

    logic        io_clk;
    logic        resetn;
    logic [9:0]  sw_in;
    logic [31:0] addr;
    logic        io_rd;
    logic [31:0] io_read_data;
    logic [1:0]  data_ready;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    io_input_scan_ctrl #(
        .NCH      (2),
        .WIDTH    (5),
        .DEBOUNCE (4),
        .SCAN_DIV (8)
    ) dut (
        .io_clk       (io_clk),
        .resetn       (resetn),
        .sw_in        (sw_in),
        .addr         (addr),
        .io_rd        (io_rd),
        .io_read_data (io_read_data),
        .data_ready   (data_ready),
        .irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, io_read_data, exp);
    endtask

    initial begin
        int  cyc;
        bool_found: begin end
        sw_in  = '1;
        addr   = 32'h0;
        io_rd  = 1'b0;
        resetn = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge io_clk);
        read_chk("rst_rd_i0", 32'h00, 32'h0);
        read_chk("rst_rd_i1", 32'h04, 32'h0);
        read_chk("rst_rd_i2", 32'h08, 32'h0);
        check("rst_data_ready", 32'(data_ready), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // ---------------- debounce commit on ch0 ----------------
        sw_in = '0;
        @(negedge io_clk);
        resetn = 1'b1;
        sw_in[4:0] = 5'h15;
        // Visits of ch0 sample at edges 9,25,41,57; the 4th visit commits at 59.
        cyc = 0;
        for (int i = 1; i <= 72; i++) begin
            @(negedge io_clk);
            if (data_ready != 2'b00 || irq != 1'b0) begin
                cyc = i;
                break;
            end
        end
        check("commit_latency", 32'(cyc), 32'd59);
        check("commit_data_ready", 32'(data_ready), 32'h1);
        check("commit_irq_not_yet", 32'(irq), 32'h0);
        read_chk("commit_in_reg0", 32'h00, 32'h15);
        @(negedge io_clk);
        check("commit_irq", 32'(irq), 32'h1);

        // ---------------- glitch rejection on ch1 ----------------
        sw_in[9:5] = 5'h1F;
        repeat (10) @(negedge io_clk);
        sw_in[9:5] = 5'h00;
        repeat (80) @(negedge io_clk);
        read_chk("glitch_in_reg1", 32'h04, 32'h0);
        check("glitch_data_ready", 32'(data_ready), 32'h1);

        // ---------------- status read clears nothing ----------------
        addr  = 32'h08;
        io_rd = 1'b1;
        @(negedge io_clk);
        io_rd = 1'b0;
        check("status_rd_keep", 32'(data_ready), 32'h1);
        read_chk("status_word", 32'h08, 32'h1);

        // ---------------- read clear on ch0 ----------------
        addr  = 32'h00;
        io_rd = 1'b1;
        @(negedge io_clk);
        io_rd = 1'b0;
        check("rdclr_data_ready", 32'(data_ready), 32'h0);
        check("rdclr_irq_lag", 32'(irq), 32'h1);
        read_chk("rdclr_value_kept", 32'h00, 32'h15);
        @(negedge io_clk);
        check("rdclr_irq", 32'(irq), 32'h0);

        // ---------------- read/commit collision on ch1 ----------------
        // First commit 0x03 to learn the phase of ch1 commit edges.
        sw_in[9:5] = 5'h03;
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge io_clk);
            if (data_ready[1]) begin
                cyc = i;
                break;
            end
        end
        check("ch1_first_commit_seen", 32'(cyc != 0), 32'h1);
        read_chk("ch1_first_value", 32'h04, 32'h03);
        // Next ch1 visits sample 14,30,46,62 edges later; 4th commits at +64.
        sw_in[9:5] = 5'h0A;
        addr  = 32'h04;
        io_rd = 1'b1;
        @(negedge io_clk);
        io_rd = 1'b0;
        check("ch1_cleared", 32'(data_ready), 32'h0);
        repeat (62) @(negedge io_clk);
        check("coll_pre_ready", 32'(data_ready), 32'h0);
        read_chk("coll_pre_value", 32'h04, 32'h03);
        io_rd = 1'b1;
        @(negedge io_clk);
        io_rd = 1'b0;
        check("coll_set_wins", 32'(data_ready), 32'h2);
        read_chk("coll_in_reg1", 32'h04, 32'h0A);

        // ---------------- mid-scan reset ----------------
        // ch1 is in S_CHECK between commit-edge-2 and commit-edge-1.
        repeat (14) @(negedge io_clk);
        sw_in  = {5'h0C, 5'h07};
        resetn = 1'b0;
        #1;
        check("mid_rst_data_ready", 32'(data_ready), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        read_chk("mid_rst_rd_i0", 32'h00, 32'h0);
        read_chk("mid_rst_rd_i1", 32'h04, 32'h0);
        read_chk("mid_rst_rd_i2", 32'h08, 32'h0);
        repeat (2) @(negedge io_clk);
        resetn = 1'b1;

        // Scan restarts at ch0: ch0 commits at edge 59, ch1 at edge 67.
        repeat (58) @(negedge io_clk);
        check("restart_none_yet", 32'(data_ready), 32'h0);
        @(negedge io_clk);
        check("restart_ch0_first", 32'(data_ready), 32'h1);
        read_chk("restart_in_reg0", 32'h00, 32'h07);
        repeat (8) @(negedge io_clk);
        check("restart_ch1_next", 32'(data_ready), 32'h3);
        read_chk("restart_in_reg1", 32'h04, 32'h0C);

        // ---------------- address range ----------------
        read_chk("addr_fc_zero", 32'hFC, 32'h0);
        read_chk("addr_0c_zero", 32'h0C, 32'h0);
        read_chk("addr_08_status", 32'h08, 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
